// File: rtl/dll_tx_tlp_replay_if.sv
// ============================================================================
//  Module   : dll_tx_tlp_replay_if
//  Brief    : TLP-in / ACK-NAK / DLLP-out bundle for the DLL transmit path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dll_tx_tlp_replay_if #(
    parameter int TLP_W = 128
);
    logic [1:0]        dlc_state_i;
    logic [TLP_W-1:0]  tlp_i;
    logic              tlp_valid_i;
    logic              tlp_ready_o;
    logic              ack_valid_i;
    logic              ack_nak_i;
    logic [11:0]       ack_seq_i;
    logic [TLP_W+47:0] dllp_o;
    logic              dllp_valid_o;
    logic              dllp_ready_i;
    logic              replay_busy_o;

    modport slave (
        input  dlc_state_i, tlp_i, tlp_valid_i, ack_valid_i, ack_nak_i,
               ack_seq_i, dllp_ready_i,
        output tlp_ready_o, dllp_o, dllp_valid_o, replay_busy_o
    );

    modport master (
        output dlc_state_i, tlp_i, tlp_valid_i, ack_valid_i, ack_nak_i,
               ack_seq_i, dllp_ready_i,
        input  tlp_ready_o, dllp_o, dllp_valid_o, replay_busy_o
    );
endinterface

`default_nettype wire

// File: rtl/dll_tx_tlp_replay.sv
// ============================================================================
//  Module   : dll_tx_tlp_replay
//  Brief    : DLL TLP transmit path: sequence numbering, LCRC, replay buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dll_tx_tlp_replay #(
    parameter int TLP_W          = 128,
    parameter int DEPTH          = 8,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dll_tx_tlp_replay_if.slave    tx_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
    localparam int EW = 12 + TLP_W;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [TW-1:0] C_TIMEOUT = TW'(REPLAY_TIMEOUT);

    typedef enum logic [1:0] {
        ST_INACTIVE = 2'd0,
        ST_NORMAL   = 2'd1,
        ST_REPLAY   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [11:0]       r_nts, r_as;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count, r_rem;
    logic [TW-1:0]     r_timer;
    logic [TLP_W+47:0] r_dllp;
    logic              r_dllp_valid;

    logic              w_active, w_on, w_free, w_range, w_ack, w_nak;
    logic              w_timeout, w_restart, w_accept, w_load;
    logic [11:0]       w_dist;
    logic [CW-1:0]     w_purge, w_count_nxt, w_rem_nxt;
    logic [AW-1:0]     w_ridx;
    logic [EW-1:0]     w_rentry;
    logic [11:0]       w_rseq;
    logic [TLP_W-1:0]  w_rtlp;

    function automatic logic [31:0] f_lcrc(input logic [11:0] seq, input logic [TLP_W-1:0] tlp);
        logic [TLP_W+31:0] v;
        logic [31:0]       acc;
        v   = {4'h0, seq, tlp, 16'h0000};
        acc = '0;
        for (int k = 0; k < (TLP_W + 32) / 32; k++) acc ^= v[k*32 +: 32];
        return acc;
    endfunction

    assign w_active  = (tx_if.dlc_state_i == 2'b11);
    assign w_on      = (r_state != ST_INACTIVE);
    assign w_free    = !r_dllp_valid || tx_if.dllp_ready_i;
    // Outstanding seqs are AS+1..AS+count, so the modular distance bounds the range.
    assign w_dist    = tx_if.ack_seq_i - r_as;
    assign w_range   = w_on && tx_if.ack_valid_i && (w_dist != 12'd0) && (w_dist <= 12'(r_count));
    assign w_nak     = w_range && tx_if.ack_nak_i;
    assign w_ack     = w_range && !tx_if.ack_nak_i;
    assign w_timeout = w_on && (r_timer == C_TIMEOUT) && !w_ack;
    assign w_restart = w_nak || w_timeout;
    assign w_purge   = w_range ? w_dist[CW-1:0] : '0;

    assign tx_if.tlp_ready_o = (r_state == ST_NORMAL) && w_active && (r_count < C_DEPTH)
                               && w_free && !w_nak;
    assign w_accept    = tx_if.tlp_ready_o && tx_if.tlp_valid_i;
    assign w_count_nxt = r_count + CW'(w_accept) - w_purge;

    // Replay walks the last r_rem entries before the tail; a purge simply clips r_rem.
    assign w_ridx   = r_tail - r_rem[AW-1:0];
    assign w_rentry = r_mem[w_ridx];
    assign w_rseq   = w_rentry[EW-1 -: 12];
    assign w_rtlp   = w_rentry[TLP_W-1:0];
    assign w_load   = (r_state == ST_REPLAY) && (r_rem != '0) && w_free && !w_range && !w_restart;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (!w_active) begin
            w_state_nxt = ST_INACTIVE;
            w_rem_nxt   = '0;
        end else if (r_state == ST_INACTIVE) begin
            w_state_nxt = ST_NORMAL;
        end else if (w_restart) begin
            w_rem_nxt = w_count_nxt;
            if (w_count_nxt != '0) w_state_nxt = ST_REPLAY;
        end else if (r_state == ST_REPLAY) begin
            if (r_rem == '0) begin
                if (w_free) w_state_nxt = ST_NORMAL;
            end else if (w_range) begin
                w_rem_nxt = (r_rem < w_count_nxt) ? r_rem : w_count_nxt;
            end else if (w_load) begin
                w_rem_nxt = r_rem - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INACTIVE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nts        <= '0;
            r_as         <= 12'hFFF;
            r_tail       <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_dllp       <= '0;
            r_dllp_valid <= 1'b0;
        end else if (!w_active) begin
            r_nts        <= '0;
            r_as         <= 12'hFFF;
            r_tail       <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_dllp       <= '0;
            r_dllp_valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tail  <= r_tail + AW'(w_accept);
            if (w_accept) r_nts <= r_nts + 12'd1;
            if (w_range)  r_as  <= tx_if.ack_seq_i;
            if (!w_on || w_range || w_restart || (r_count == '0)) r_timer <= '0;
            else                                                 r_timer <= r_timer + TW'(1);
            if (w_accept) begin
                r_dllp       <= {4'h0, r_nts, tx_if.tlp_i, f_lcrc(r_nts, tx_if.tlp_i)};
                r_dllp_valid <= 1'b1;
            end else if (w_load) begin
                r_dllp       <= {4'h0, w_rseq, w_rtlp, f_lcrc(w_rseq, w_rtlp)};
                r_dllp_valid <= 1'b1;
            end else if (tx_if.dllp_ready_i) begin
                r_dllp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_tail] <= {r_nts, tx_if.tlp_i};
    end

    assign tx_if.dllp_o        = r_dllp;
    assign tx_if.dllp_valid_o  = r_dllp_valid;
    assign tx_if.replay_busy_o = (r_state == ST_REPLAY);

endmodule

`default_nettype wire
